// File: rtl/cp0_timer_intr_pkg.sv
// Shared CP0 timer definitions: CP0 {rd,sel} addresses, the Count reset value and
// the mfc0 address decode used by the timer block.
package cp0_timer_intr_pkg;

    localparam logic [7:0]  CP0ADDR_COUNT   = 8'h48;
    localparam logic [7:0]  CP0ADDR_COMPARE = 8'h58;
    localparam logic [31:0] COUNT_INI       = 32'h0;

    typedef enum logic [1:0] {
        RD_NONE    = 2'd0,
        RD_COUNT   = 2'd1,
        RD_COMPARE = 2'd2
    } rd_sel_e;

    function automatic rd_sel_e decode_rd(input logic [7:0] addr);
        if (addr == CP0ADDR_COUNT) begin
            return RD_COUNT;
        end else if (addr == CP0ADDR_COMPARE) begin
            return RD_COMPARE;
        end
        return RD_NONE;
    endfunction

endpackage

// File: rtl/cp0_count_div.sv
// Count prescaler: toggles div_phase each cycle (COUNT_DIV=2) and flags the
// cycles on which Count advances; a Count write restarts the phase at 0.
module cp0_count_div #(
    parameter int COUNT_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic inc_o
);

    logic div_phase_q, div_phase_d;

    always_comb begin
        div_phase_d = 1'b0;
        if (COUNT_DIV == 2) begin
            div_phase_d = restart_i ? 1'b0 : ~div_phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_phase_q <= 1'b0;
        end else begin
            div_phase_q <= div_phase_d;
        end
    end

    assign inc_o = (COUNT_DIV == 1) ? 1'b1 : div_phase_q;

endmodule

// File: rtl/cp0_timer_intr.sv
// CP0 Count timer and timer interrupt (Cause.TI / IP7): owns Count, compares it
// against the externally held Compare value and serves mfc0 reads of both.
module cp0_timer_intr
    import cp0_timer_intr_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [31:0] mtc0_data,
    input  logic [7:0]  cp0_addr,
    input  logic [31:0] cp0_Compare_data,
    input  logic        mfc0_re,
    output logic [31:0] mfc0_data,
    output logic        mfc0_hit,
    output logic        timer_int
);

    logic [31:0] count_q, count_d;
    logic        armed_q, armed_d;
    logic        ti_q, ti_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hit_q, hit_d;

    logic        wr_count;
    logic        wr_compare;
    logic        count_inc;
    logic        match;
    rd_sel_e     rd_sel;

    assign wr_count   = mtc0_we && (cp0_addr == CP0ADDR_COUNT);
    assign wr_compare = mtc0_we && (cp0_addr == CP0ADDR_COMPARE);
    assign rd_sel     = decode_rd(cp0_addr);

    cp0_count_div #(
        .COUNT_DIV(COUNT_DIV)
    ) u_count_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart_i(wr_count),
        .inc_o    (count_inc)
    );

    // Compare has no reset, so matching is held off until software has written it once.
    assign match = armed_q && (count_q == cp0_Compare_data);

    always_comb begin
        count_d = count_q;
        if (wr_count) begin
            count_d = mtc0_data;
        end else if (count_inc) begin
            count_d = count_q + 32'd1;
        end

        armed_d = armed_q || wr_compare;

        ti_d = ti_q;
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (match) begin
            ti_d = 1'b1;
        end

        // Reads sample pre-write, pre-increment values; no read leaves the data latched.
        rdata_d = rdata_q;
        hit_d   = 1'b0;
        if (mfc0_re) begin
            unique case (rd_sel)
                RD_COUNT: begin
                    rdata_d = count_q;
                    hit_d   = 1'b1;
                end
                RD_COMPARE: begin
                    rdata_d = cp0_Compare_data;
                    hit_d   = 1'b1;
                end
                default: begin
                    rdata_d = 32'h0;
                    hit_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= COUNT_INI;
            armed_q <= 1'b0;
            ti_q    <= 1'b0;
            rdata_q <= 32'h0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
            ti_q    <= ti_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign mfc0_data = rdata_q;
    assign mfc0_hit  = hit_q;
    assign timer_int = ti_q;

endmodule
